// File: rtl/mem_access_ctrl_if.sv
// Data-bus req/ack channel between the MEM-stage access controller (master)
// and the data-memory bus slave.
interface mem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: lane steering, load extension and
// pipeline stall until bus ack. Define MEM_ADDR_ERR_EN to trap misaligned accesses.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif
`ifndef EC_AdEL
`define EC_AdEL 5'h04
`endif
`ifndef EC_AdES
`define EC_AdES 5'h05
`endif
`ifndef LB
`define LB  8'b11100000
`endif
`ifndef LH
`define LH  8'b11100001
`endif
`ifndef LW
`define LW  8'b11100011
`endif
`ifndef LBU
`define LBU 8'b11100100
`endif
`ifndef LHU
`define LHU 8'b11100101
`endif
`ifndef SB
`define SB  8'b11101000
`endif
`ifndef SH
`define SH  8'b11101001
`endif
`ifndef SW
`define SW  8'b11101011
`endif

module mem_access_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 mem_aluop,
  input  logic [31:0]                mem_mem_addr,
  input  logic [31:0]                mem_reg2,
  input  logic [31:0]                mem_wdata,
  input  logic [`EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic                       flush,
  output logic [31:0]                wdata_o,
  output logic [`EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic [31:0]                badvaddr_o,
  output logic                       stallreq,
  mem_access_ctrl_if.master          dbus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] ldata_q, ldata_d;

  logic        is_load, is_store, addr_err, pending;
  logic [3:0]  be_c;
  logic        we_c;
  logic [31:0] wdata_c;

  function automatic logic load_op(input logic [7:0] op);
    return (op == `LB) || (op == `LBU) || (op == `LH) || (op == `LHU) || (op == `LW);
  endfunction

  function automatic logic store_op(input logic [7:0] op);
    return (op == `SB) || (op == `SH) || (op == `SW);
  endfunction

  function automatic logic [31:0] load_extend(input logic [7:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = lane[1] ? d[31:16] : d[15:0];
    case (op)
      `LB:     return {{24{b[7]}}, b};
      `LBU:    return {24'h0, b};
      `LH:     return {{16{h[15]}}, h};
      `LHU:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  assign is_load  = load_op(mem_aluop);
  assign is_store = store_op(mem_aluop);

`ifdef MEM_ADDR_ERR_EN
  always_comb begin
    addr_err = 1'b0;
    case (mem_aluop)
      `LH, `LHU, `SH: addr_err = mem_mem_addr[0];
      `LW, `SW:       addr_err = (mem_mem_addr[1:0] != 2'b00);
      default:        addr_err = 1'b0;
    endcase
  end

  // An upstream exception wins over our own address fault.
  always_comb begin
    exc_code_o = exc_code_i;
    badvaddr_o = '0;
    if (exc_code_i == `EC_None && addr_err) begin
      exc_code_o = is_load ? `EC_AdEL : `EC_AdES;
      badvaddr_o = mem_mem_addr;
    end
  end
`else
  assign addr_err   = 1'b0;
  assign exc_code_o = exc_code_i;
  assign badvaddr_o = '0;
`endif

  assign pending = (is_load || is_store) && (exc_code_i == `EC_None) && !addr_err;

  always_comb begin
    be_c    = 4'b1111;
    we_c    = 1'b0;
    wdata_c = '0;
    case (mem_aluop)
      `SB: begin
        we_c    = 1'b1;
        be_c    = 4'b0001 << mem_mem_addr[1:0];
        wdata_c = {4{mem_reg2[7:0]}};
      end
      `SH: begin
        we_c    = 1'b1;
        be_c    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_reg2[15:0]}};
      end
      `SW: begin
        we_c    = 1'b1;
        wdata_c = mem_reg2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    lane_d  = lane_q;
    ldata_d = ldata_q;
    case (state_q)
      IDLE: begin
        if (pending && !flush) begin
          state_d = REQ;
          addr_d  = {mem_mem_addr[31:2], 2'b00};
          be_d    = be_c;
          we_d    = we_c;
          wdata_d = wdata_c;
          op_d    = mem_aluop;
          lane_d  = mem_mem_addr[1:0];
        end
      end
      REQ: begin
        if (dbus.ack) begin
          state_d = DONE;
          if (load_op(op_q)) ldata_d = load_extend(op_q, lane_q, dbus.rdata);
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE:  state_d = IDLE;
      // A flushed transaction still runs to its ack; the data is dropped.
      DRAIN: if (dbus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      ldata_q <= ldata_d;
    end
  end

  assign dbus.req   = (state_q == REQ) || (state_q == DRAIN);
  assign dbus.we    = we_q;
  assign dbus.be    = be_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;

  assign stallreq = (pending && (state_q == IDLE || state_q == REQ)) || (state_q == DRAIN);
  assign wdata_o  = (state_q == DONE && load_op(op_q)) ? ldata_q : mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the bench plays the bus slave.
// Build with +define+MEM_ADDR_ERR_EN to cover the misalignment trap.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif
`ifndef EC_AdEL
`define EC_AdEL 5'h04
`endif
`ifndef EC_AdES
`define EC_AdES 5'h05
`endif
`ifndef LB
`define LB  8'b11100000
`endif
`ifndef LH
`define LH  8'b11100001
`endif
`ifndef LW
`define LW  8'b11100011
`endif
`ifndef LBU
`define LBU 8'b11100100
`endif
`ifndef LHU
`define LHU 8'b11100101
`endif
`ifndef SB
`define SB  8'b11101000
`endif
`ifndef SH
`define SH  8'b11101001
`endif
`ifndef SW
`define SW  8'b11101011
`endif

module tb_mem_access_ctrl;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [7:0]                 mem_aluop;
    logic [31:0]                mem_mem_addr, mem_reg2, mem_wdata;
    logic [`EXC_CODE_WIDTH-1:0] exc_code_i;
    logic                       flush;
    logic [31:0]                wdata_o, badvaddr_o;
    logic [`EXC_CODE_WIDTH-1:0] exc_code_o;
    logic                       stallreq;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl_if dbus ();

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .mem_wdata    (mem_wdata),
        .exc_code_i   (exc_code_i),
        .flush        (flush),
        .wdata_o      (wdata_o),
        .exc_code_o   (exc_code_o),
        .badvaddr_o   (badvaddr_o),
        .stallreq     (stallreq),
        .dbus         (dbus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; mem_aluop = 8'h00; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
        mem_wdata = 32'h55AA_1234; exc_code_i = `EC_None; flush = 1'b0;
        dbus.ack = 1'b0; dbus.rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dbus.req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", dbus.req); end
        checks++; if (dbus.we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b want 0", dbus.we); end
        checks++; if (dbus.be !== 4'h0) begin failures++; $display("FAIL rst_be: got %h want 0", dbus.be); end
        checks++; if (dbus.addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", dbus.addr); end
        checks++; if (dbus.wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h want 0", dbus.wdata); end
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", stallreq); end
        checks++; if (wdata_o !== 32'h55AA_1234) begin failures++; $display("FAIL rst_wdata_o: got %h want 55aa1234", wdata_o); end
        checks++; if (exc_code_o !== `EC_None || badvaddr_o !== 32'h0) begin failures++; $display("FAIL rst_exc: got %h/%h want %h/0", exc_code_o, badvaddr_o, `EC_None); end
        rst = 1'b0;
    endtask

    // LW with ack in the second request cycle: stall spans three cycles.
    task automatic test_lw();
        int stall_cnt = 0;
        @(negedge clk);
        mem_aluop = `LW; mem_mem_addr = 32'h100; mem_wdata = 32'h1111_1111; #1;
        stall_cnt += int'(stallreq);
        checks++; if (stallreq !== 1'b1 || dbus.req !== 1'b0) begin failures++; $display("FAIL lw_c0: got stall=%b req=%b want 1/0", stallreq, dbus.req); end
        @(negedge clk); #1;
        stall_cnt += int'(stallreq);
        checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h100 || dbus.be !== 4'hF || dbus.we !== 1'b0) begin
            failures++; $display("FAIL lw_c1_bus: got req=%b addr=%h be=%h we=%b want 1/100/f/0", dbus.req, dbus.addr, dbus.be, dbus.we); end
        @(negedge clk);
        dbus.ack = 1'b1; dbus.rdata = 32'hDEAD_BEEF; #1;
        stall_cnt += int'(stallreq);
        checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h100) begin failures++; $display("FAIL lw_c2_hold: got req=%b addr=%h want 1/100", dbus.req, dbus.addr); end
        @(negedge clk);
        dbus.ack = 1'b0; dbus.rdata = 32'h0; #1;
        stall_cnt += int'(stallreq);
        checks++; if (dbus.req !== 1'b0 || stallreq !== 1'b0) begin failures++; $display("FAIL lw_done_ctl: got req=%b stall=%b want 0/0", dbus.req, stallreq); end
        checks++; if (wdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_done_data: got %h want deadbeef", wdata_o); end
        checks++; if (stall_cnt != 3) begin failures++; $display("FAIL lw_stall_cycles: got %0d want 3", stall_cnt); end
        mem_aluop = 8'h00; mem_wdata = 32'h2222_2222;
        @(negedge clk); #1;
        checks++; if (wdata_o !== 32'h2222_2222 || stallreq !== 1'b0 || dbus.req !== 1'b0) begin
            failures++; $display("FAIL lw_after: got wdata=%h stall=%b req=%b want 22222222/0/0", wdata_o, stallreq, dbus.req); end
    endtask

    // Sub-word loads with zero-wait ack.
    task automatic test_load_extend();
        logic [7:0]  ops   [6] = '{`LB, `LBU, `LH, `LHU, `LH, `LB};
        logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
        logic [31:0] rd    [6] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_1234, 32'h8001_1234, 32'h8001_7FFE, 32'h0000_7F00};
        logic [31:0] exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFE, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_aluop = ops[i]; mem_mem_addr = addrs[i]; mem_wdata = 32'h0; #1;
            @(negedge clk);
            dbus.ack = 1'b1; dbus.rdata = rd[i]; #1;
            checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h100 || dbus.be !== 4'hF) begin
                failures++; $display("FAIL ld%0d_bus: got req=%b addr=%h be=%h want 1/100/f", i, dbus.req, dbus.addr, dbus.be); end
            @(negedge clk);
            dbus.ack = 1'b0; dbus.rdata = 32'h0; #1;
            checks++; if (wdata_o !== exp[i] || stallreq !== 1'b0) begin
                failures++; $display("FAIL ld%0d_data: got %h stall=%b want %h/0", i, wdata_o, stallreq, exp[i]); end
            mem_aluop = 8'h00;
        end
    endtask

    task automatic test_store();
        logic [7:0]  ops   [2] = '{`SH, `SB};
        logic [31:0] addrs [2] = '{32'h206, 32'h201};
        logic [31:0] rg    [2] = '{32'h1234_ABCD, 32'h0000_00EF};
        logic [31:0] ewd   [2] = '{32'hABCD_ABCD, 32'hEFEF_EFEF};
        logic [3:0]  ebe   [2] = '{4'b1100, 4'b0010};
        logic [31:0] eadr  [2] = '{32'h204, 32'h200};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_aluop = ops[i]; mem_mem_addr = addrs[i]; mem_reg2 = rg[i]; mem_wdata = 32'h0BAD_0000; #1;
            checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL st%0d_c0_stall: got %b want 1", i, stallreq); end
            @(negedge clk);
            dbus.ack = 1'b1; #1;
            checks++; if (dbus.req !== 1'b1 || dbus.we !== 1'b1 || dbus.be !== ebe[i] || dbus.wdata !== ewd[i] || dbus.addr !== eadr[i]) begin
                failures++; $display("FAIL st%0d_bus: got req=%b we=%b be=%b wdata=%h addr=%h want 1/1/%b/%h/%h",
                                     i, dbus.req, dbus.we, dbus.be, dbus.wdata, dbus.addr, ebe[i], ewd[i], eadr[i]); end
            @(negedge clk);
            dbus.ack = 1'b0; #1;
            checks++; if (stallreq !== 1'b0 || dbus.req !== 1'b0 || wdata_o !== 32'h0BAD_0000) begin
                failures++; $display("FAIL st%0d_done: got stall=%b req=%b wdata=%h want 0/0/0bad0000", i, stallreq, dbus.req, wdata_o); end
            mem_aluop = 8'h00;
        end
    endtask

    // Flush during the first REQ cycle: request held until the late ack.
    task automatic test_flush();
        @(negedge clk);
        mem_aluop = `LW; mem_mem_addr = 32'h400; mem_wdata = 32'h3333_3333; #1;
        @(negedge clk);
        flush = 1'b1; #1;
        checks++; if (dbus.req !== 1'b1 || stallreq !== 1'b1) begin failures++; $display("FAIL fl_c1: got req=%b stall=%b want 1/1", dbus.req, stallreq); end
        @(negedge clk);
        flush = 1'b0; mem_aluop = 8'h00;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) begin dbus.ack = 1'b1; dbus.rdata = 32'hCAFE_F00D; end
            #1;
            checks++; if (dbus.req !== 1'b1 || stallreq !== 1'b1 || dbus.addr !== 32'h400) begin
                failures++; $display("FAIL fl_drain_c%0d: got req=%b stall=%b addr=%h want 1/1/400", c, dbus.req, stallreq, dbus.addr); end
            @(negedge clk);
        end
        dbus.ack = 1'b0; dbus.rdata = 32'h0; #1;
        checks++; if (dbus.req !== 1'b0 || stallreq !== 1'b0 || wdata_o !== 32'h3333_3333) begin
            failures++; $display("FAIL fl_end: got req=%b stall=%b wdata=%h want 0/0/33333333", dbus.req, stallreq, wdata_o); end
    endtask

    task automatic test_misalign();
        // Upstream exception suppresses the access in either build.
        @(negedge clk);
        mem_aluop = `SW; mem_mem_addr = 32'h302; mem_reg2 = 32'hA5A5_A5A5; exc_code_i = 5'h0C; #1;
        checks++; if (stallreq !== 1'b0 || exc_code_o !== 5'h0C || badvaddr_o !== 32'h0) begin
            failures++; $display("FAIL mis_upstream: got stall=%b exc=%h bva=%h want 0/0c/0", stallreq, exc_code_o, badvaddr_o); end
        @(negedge clk); #1;
        checks++; if (dbus.req !== 1'b0) begin failures++; $display("FAIL mis_upstream_req: got %b want 0", dbus.req); end
        exc_code_i = `EC_None;
`ifdef MEM_ADDR_ERR_EN
        #1;
        checks++; if (stallreq !== 1'b0 || exc_code_o !== `EC_AdES || badvaddr_o !== 32'h302) begin
            failures++; $display("FAIL mis_sw: got stall=%b exc=%h bva=%h want 0/%h/302", stallreq, exc_code_o, badvaddr_o, `EC_AdES); end
        @(negedge clk);
        mem_aluop = `LH; mem_mem_addr = 32'h101; #1;
        checks++; if (dbus.req !== 1'b0 || stallreq !== 1'b0 || exc_code_o !== `EC_AdEL || badvaddr_o !== 32'h101) begin
            failures++; $display("FAIL mis_lh: got req=%b stall=%b exc=%h bva=%h want 0/0/%h/101", dbus.req, stallreq, exc_code_o, badvaddr_o, `EC_AdEL); end
        @(negedge clk); #1;
        checks++; if (dbus.req !== 1'b0) begin failures++; $display("FAIL mis_lh_req: got %b want 0", dbus.req); end
`else
        #1;
        checks++; if (stallreq !== 1'b1 || exc_code_o !== `EC_None || badvaddr_o !== 32'h0) begin
            failures++; $display("FAIL mis_sw_c0: got stall=%b exc=%h bva=%h want 1/%h/0", stallreq, exc_code_o, badvaddr_o, `EC_None); end
        @(negedge clk);
        dbus.ack = 1'b1; #1;
        checks++; if (dbus.req !== 1'b1 || dbus.be !== 4'hF || dbus.addr !== 32'h300 || dbus.wdata !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL mis_sw_bus: got req=%b be=%h addr=%h wdata=%h want 1/f/300/a5a5a5a5", dbus.req, dbus.be, dbus.addr, dbus.wdata); end
        @(negedge clk);
        dbus.ack = 1'b0; #1;
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL mis_sw_done: got stall=%b want 0", stallreq); end
`endif
        mem_aluop = 8'h00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_aluop = `SW; mem_mem_addr = 32'h500; mem_reg2 = 32'h7777_7777; #1;
        @(negedge clk); #1;
        checks++; if (dbus.req !== 1'b1 || dbus.we !== 1'b1) begin failures++; $display("FAIL rm_req: got req=%b we=%b want 1/1", dbus.req, dbus.we); end
        #1 rst = 1'b1; #1;
        checks++; if (dbus.req !== 1'b0 || dbus.we !== 1'b0 || dbus.be !== 4'h0 || dbus.addr !== 32'h0 || dbus.wdata !== 32'h0) begin
            failures++; $display("FAIL rm_async: got req=%b we=%b be=%h addr=%h wdata=%h want all 0", dbus.req, dbus.we, dbus.be, dbus.addr, dbus.wdata); end
        mem_aluop = 8'h00;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (dbus.req !== 1'b0 || stallreq !== 1'b0) begin failures++; $display("FAIL rm_after: got req=%b stall=%b want 0/0", dbus.req, stallreq); end
    endtask

    // Second LW becomes visible right after DONE and starts from IDLE.
    task automatic test_back_to_back();
        @(negedge clk);
        mem_aluop = `LW; mem_mem_addr = 32'h10; #1;
        @(negedge clk);
        dbus.ack = 1'b1; dbus.rdata = 32'h0000_0001; #1;
        @(negedge clk);
        dbus.ack = 1'b0; #1;
        checks++; if (wdata_o !== 32'h1 || stallreq !== 1'b0) begin failures++; $display("FAIL b2b_first: got %h stall=%b want 1/0", wdata_o, stallreq); end
        mem_mem_addr = 32'h14;
        @(negedge clk); #1;
        checks++; if (stallreq !== 1'b1 || dbus.req !== 1'b0) begin failures++; $display("FAIL b2b_idle: got stall=%b req=%b want 1/0", stallreq, dbus.req); end
        @(negedge clk);
        dbus.ack = 1'b1; dbus.rdata = 32'h0000_0002; #1;
        checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h14) begin failures++; $display("FAIL b2b_req: got req=%b addr=%h want 1/14", dbus.req, dbus.addr); end
        @(negedge clk);
        dbus.ack = 1'b0; #1;
        checks++; if (wdata_o !== 32'h2 || stallreq !== 1'b0) begin failures++; $display("FAIL b2b_second: got %h stall=%b want 2/0", wdata_o, stallreq); end
        mem_aluop = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_flush();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
